// File: rtl/ro_freq_counter.sv
// Ring-oscillator frequency counter: counts synchronized ro_in rising edges over a WINDOW-cycle gate, Wishbone slave, ack one cycle after request.
// Optional level interrupt irq_o (registered STATUS.DONE) when RO_FREQ_IRQ_EN is defined.
module ro_freq_counter #(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned WIN_W    = 24,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ro_in,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o
`ifdef RO_FREQ_IRQ_EN
  ,
  output logic        irq_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_sync1;
  logic               r_sync2;
  logic               r_hist;
  logic               r_ack;
  logic [31:0]        r_dat;
  logic [WIN_W-1:0]   r_window;
  logic [WIN_W-1:0]   r_remaining;
  logic [CNT_W-1:0]   r_edges;
  logic [CNT_W-1:0]   r_count;
  logic               r_cont;
  logic               r_done;
  logic               r_ovf;

  logic               w_edge;
  logic               w_match;
  logic               w_acc;
  logic               w_wr;
  logic               w_rd;
  logic [1:0]         w_off;
  logic               w_ctrl_wr;
  logic               w_win_wr;
  logic               w_stat_wr;
  logic               w_start;
  logic               w_abort;
  logic               w_win_nz;
  logic               w_busy;
  logic               w_edges_max;
  logic               w_load;
  logic               w_clr;
  logic               w_count_en;
  logic               w_publish;
  logic               w_ovf_set;
  logic [31:0]        w_rdata;
  logic               w_unused_ok;

  assign w_unused_ok = &{1'b0, wbs_sel_i, wbs_adr_i[1:0], wbs_dat_i};

  // ro_in is asynchronous: two flops for metastability, a third for edge history
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_hist  <= 1'b0;
    end else begin
      r_sync1 <= ro_in;
      r_sync2 <= r_sync1;
      r_hist  <= r_sync2;
    end
  end

  assign w_edge = r_sync2 & ~r_hist;

  assign w_match   = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign w_acc     = w_match & ~r_ack;
  assign w_wr      = w_acc & wbs_we_i;
  assign w_rd      = w_acc & ~wbs_we_i;
  assign w_off     = wbs_adr_i[3:2];
  assign w_ctrl_wr = w_wr & (w_off == 2'd0);
  assign w_win_wr  = w_wr & (w_off == 2'd1);
  assign w_stat_wr = w_wr & (w_off == 2'd3);
  assign w_start   = w_ctrl_wr & wbs_dat_i[0];
  assign w_abort   = w_ctrl_wr & wbs_dat_i[1];

  assign w_win_nz    = |r_window;
  assign w_busy      = (r_state != ST_IDLE);
  assign w_edges_max = &r_edges;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ABORT overrides everything, including the DONE-cycle publish
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_clr       = 1'b0;
    w_count_en  = 1'b0;
    w_publish   = 1'b0;
    if (w_abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            w_clr = 1'b1;
            if (w_win_nz) begin
              w_load      = 1'b1;
              w_state_nxt = ST_COUNT;
            end else begin
              w_state_nxt = ST_DONE;
            end
          end
        end
        ST_COUNT: begin
          w_count_en = 1'b1;
          if (r_remaining == WIN_W'(1)) begin
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          w_publish = 1'b1;
          if (r_cont && w_win_nz) begin
            w_load      = 1'b1;
            w_clr       = 1'b1;
            w_state_nxt = ST_COUNT;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_ovf_set = w_count_en & w_edge & w_edges_max;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_remaining <= '0;
      r_edges     <= '0;
      r_count     <= '0;
    end else begin
      if (w_load) begin
        r_remaining <= r_window;
      end else if (w_count_en) begin
        r_remaining <= r_remaining - WIN_W'(1);
      end
      if (w_clr) begin
        r_edges <= '0;
      end else if (w_count_en && w_edge && !w_edges_max) begin
        r_edges <= r_edges + CNT_W'(1);
      end
      if (w_publish) begin
        r_count <= r_edges;
      end
    end
  end

  // Flag sets take priority over a same-cycle write-1-to-clear
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_window <= '0;
      r_cont   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_win_wr) begin
        r_window <= wbs_dat_i[WIN_W-1:0];
      end
      if (w_ctrl_wr) begin
        r_cont <= wbs_dat_i[2] & ~wbs_dat_i[1];
      end
      r_done <= (r_done & ~(w_stat_wr & wbs_dat_i[1])) | w_publish;
      r_ovf  <= (r_ovf  & ~(w_stat_wr & wbs_dat_i[2])) | w_ovf_set;
    end
  end

  always_comb begin
    w_rdata = 32'd0;
    case (w_off)
      2'd0:    w_rdata = {29'd0, r_cont, 2'b00};
      2'd1:    w_rdata = 32'(r_window);
      2'd2:    w_rdata = 32'(r_count);
      default: w_rdata = {29'd0, r_ovf, r_done, w_busy};
    endcase
  end

  // Ack drops for a cycle after each acknowledge so a held strobe is not double-acked
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= 32'd0;
    end else begin
      r_ack <= w_acc;
      r_dat <= w_rd ? w_rdata : 32'd0;
    end
  end

  assign wbs_ack_o = r_ack;
  assign wbs_dat_o = r_dat;

`ifdef RO_FREQ_IRQ_EN
  logic r_irq;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_done;
    end
  end

  assign irq_o = r_irq;
`endif

endmodule

// File: doc/ro_freq_counter.md
RO_FREQ_COUNTER -- requirements
Module: ro_freq_counter

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32, giving the edge-counter and result width.
REQ-002 The block SHALL have parameter WIN_W, default 24, giving the gate-window register width.
REQ-003 The block SHALL have parameter BASE_ADR, default 32'h3000_0000, matched against wbs_adr_i[31:4].
REQ-004 The block SHALL have port wb_clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port wb_rst_i, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-006 The block SHALL have port ro_in, input, 1 bit: the muxed ring-oscillator output, asynchronous to wb_clk_i.
REQ-007 The block SHALL have ports wbs_stb_i, wbs_cyc_i and wbs_we_i, each input, 1 bit: the Wishbone slave strobe, cycle and write-enable.
REQ-008 The block SHALL have port wbs_sel_i, input, 4 bits: byte selects, which are ignored because all writes are full-word.
REQ-009 The block SHALL have ports wbs_adr_i and wbs_dat_i, each input, 32 bits: the address and write data.
REQ-010 The block SHALL have port wbs_ack_o, output, 1 bit, and port wbs_dat_o, output, 32 bits.
REQ-011 When RO_FREQ_IRQ_EN is defined, the block SHALL have port irq_o, output, 1 bit.

Function
REQ-012 ro_in SHALL pass through a 2-flop synchronizer plus a history flop; a rising edge is detected when sync=1 and hist=0.
REQ-013 The register map (offset = adr[3:2]) SHALL be: 0x0 CTRL (write-only; bit0 START, bit1 ABORT, bit2 CONT, where CONT is retained and readable), 0x4 WINDOW (R/W, WIN_W bits, zero-extended), 0x8 COUNT (read-only), 0xC STATUS (bit0 BUSY; bit1 DONE, write-1-to-clear; bit2 OVF, write-1-to-clear).
REQ-014 wbs_ack_o SHALL assert exactly one cycle after a cycle with stb&cyc&address match and ack low, then drop for one cycle, so there is no double ack on a held strobe.
REQ-015 Reads SHALL return data in the ack cycle; an unmatched address SHALL produce no ack; write-only bits SHALL read as 0.
REQ-016 The FSM states SHALL be IDLE, COUNT and DONE.
REQ-017 In IDLE, a START with WINDOW≠0 SHALL load remaining=WINDOW, clear the edge counter and go to COUNT.
REQ-018 In IDLE, a START with WINDOW=0 SHALL go to DONE with a result of 0.
REQ-019 In COUNT, each cycle SHALL add 1 to the edge counter if an edge is detected and decrement remaining; the cycle in which remaining==1 is the last sampled cycle, after which the FSM goes to DONE.
REQ-020 A window of N SHALL sample exactly N cycles; the 2-cycle synchronizer latency is not compensated.
REQ-021 DONE (1 cycle) SHALL copy the edge counter to COUNT and set STATUS.DONE; the next state is COUNT (reloaded from WINDOW) if CONT=1 and WINDOW≠0, else IDLE.
REQ-022 BUSY SHALL read 1 in COUNT and DONE.
REQ-023 The edge counter SHALL saturate at all-ones and set STATUS.OVF, which stays set until cleared.
REQ-024 START received in COUNT or DONE SHALL be ignored.
REQ-025 ABORT in any state SHALL go to IDLE, leave COUNT and DONE unchanged and clear CONT.
REQ-026 When START and ABORT are written simultaneously, ABORT SHALL win.
REQ-027 A WINDOW write during COUNT SHALL take effect only at the next load.
REQ-028 When a W1C write and a set of the same flag occur in the same cycle, the set SHALL win.

Reset
REQ-029 Asserting wb_rst_i SHALL immediately set: state IDLE, wbs_ack_o=0, wbs_dat_o=0, COUNT=0, WINDOW=0, CONT=0, DONE=0, OVF=0, synchronizer flops=0 and irq_o=0.
REQ-030 Reset mid-COUNT SHALL discard the partial count; no DONE results.

Configuration
REQ-031 With macro RO_FREQ_IRQ_EN defined, irq_o SHALL be a registered copy of STATUS.DONE, i.e. level, cleared by W1C.
REQ-032 Without RO_FREQ_IRQ_EN, irq_o and its flop SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-033 ro_in with period 8 clocks, WINDOW=800, START -> DONE after 800+1 cycles, COUNT=100 (±1 for phase), OVF=0.
REQ-034 WINDOW=0, START -> DONE=1 on the following cycle, COUNT=0, BUSY=0 two cycles after the write.
REQ-035 CNT_W=4, ro_in period 4, WINDOW=100 -> COUNT=15, OVF=1; a W1C of 0x4 to STATUS clears OVF only.
REQ-036 START, then ABORT at cycle 50 of WINDOW=200 -> IDLE, COUNT keeps its prior value, DONE stays 0; START+ABORT in one write -> stays IDLE.
REQ-037 CONT=1, WINDOW=16 -> DONE pulses every 17 cycles, and irq_o is high once DONE sets when RO_FREQ_IRQ_EN is defined; assert wb_rst_i mid-window -> all outputs 0 in the same cycle.
REQ-038 Held strobe for 4 cycles -> wbs_ack_o pattern 0,1,0,1; read of an unmapped offset -> 0.
